// File: rtl/ship_life_ctrl_if.sv
// Signal bundle between the ship life-cycle controller and its neighbours:
// collision detector, buttons, ship motion block and the ship/explosion drawers.
interface ship_life_ctrl_if #(
   parameter int LIVES = 3
);
   localparam int LW = $clog2(LIVES + 1);

   logic          frame_tick;
   logic          start_game;
   logic          collision;
   logic          spawn_clear;
   logic          thrust_btn;
   logic          ship_respawn;
   logic          thrust_en;
   logic          ship_visible;
   logic          collide_en;
   logic          explode_active;
   logic [LW-1:0] lives_left;
   logic          game_over;
   logic [2:0]    state_dbg;

   // master: the life-cycle controller; slave: the blocks around it
   modport master (
      input  frame_tick, start_game, collision, spawn_clear, thrust_btn,
      output ship_respawn, thrust_en, ship_visible, collide_en,
             explode_active, lives_left, game_over, state_dbg
   );

   modport slave (
      output frame_tick, start_game, collision, spawn_clear, thrust_btn,
      input  ship_respawn, thrust_en, ship_visible, collide_en,
             explode_active, lives_left, game_over, state_dbg
   );
endinterface

// File: rtl/ship_life_ctrl.sv
// Ship life-cycle sequencer: spawn, invulnerability blink, death explosion,
// respawn hold-off and game over, with the remaining-lives counter.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | powered up, waiting for the first start press
// SPAWN     | one clk: respawn pulse to motion block, ship at centre
// INVULN    | blinking ship, collisions ignored, timed by frame ticks
// ALIVE     | normal play, any collision kills the ship
// EXPLODE   | explosion animation, timed by frame ticks
// WAIT_RESP | hold-off before respawn, also waits for a clear centre
// GAME_OVER | no lives left, banner shown until start is pressed again
module ship_life_ctrl #(
   parameter int LIVES          = 3,
   parameter int INVULN_FRAMES  = 120,
   parameter int EXPLODE_FRAMES = 60,
   parameter int RESPAWN_FRAMES = 90,
   parameter int BLINK_LOG2     = 3
) (
   input  logic             clk,
   input  logic             resetN,
   ship_life_ctrl_if.master bus
);
   localparam int LW     = $clog2(LIVES + 1);
   localparam int MAXF_A = (INVULN_FRAMES > EXPLODE_FRAMES) ? INVULN_FRAMES : EXPLODE_FRAMES;
   localparam int MAXF   = (MAXF_A > RESPAWN_FRAMES) ? MAXF_A : RESPAWN_FRAMES;
   localparam int CW     = $clog2(MAXF + 1);

   localparam logic [CW-1:0] INV_LAST  = CW'(INVULN_FRAMES - 1);
   localparam logic [CW-1:0] EXP_LAST  = CW'(EXPLODE_FRAMES - 1);
   localparam logic [CW-1:0] RESP_SAT  = CW'(RESPAWN_FRAMES);
   localparam logic [LW-1:0] LIVES_INI = LW'(LIVES);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SPAWN     = 3'd1,
      INVULN    = 3'd2,
      ALIVE     = 3'd3,
      EXPLODE   = 3'd4,
      WAIT_RESP = 3'd5,
      GAME_OVER = 3'd6
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] frame_cnt, frame_cnt_nx;
   logic [LW-1:0] lives, lives_nx;
   logic          start_d;
   logic          start_rise;
   logic          blink_on;

   assign start_rise = bus.start_game & ~start_d;

   // a blink bit above the counter width never toggles: ship stays visible
   generate
      if (BLINK_LOG2 < CW) begin : g_blink
         assign blink_on = ~frame_cnt[BLINK_LOG2];
      end else begin : g_no_blink
         assign blink_on = 1'b1;
      end
   endgenerate

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state     <= IDLE;
         frame_cnt <= '0;
         lives     <= '0;
         start_d   <= 1'b0;
      end else begin
         state     <= state_nx;
         frame_cnt <= frame_cnt_nx;
         lives     <= lives_nx;
         start_d   <= bus.start_game;
      end
   end

   always_comb begin
      state_nx           = state;
      frame_cnt_nx       = frame_cnt;
      lives_nx           = lives;
      bus.ship_respawn   = 1'b0;
      bus.ship_visible   = 1'b0;
      bus.thrust_en      = 1'b0;
      bus.collide_en     = 1'b0;
      bus.explode_active = 1'b0;
      bus.game_over      = 1'b0;

      case (state)
         IDLE: begin
            if (start_rise) begin
               state_nx = SPAWN;
               lives_nx = LIVES_INI;
            end
         end
         SPAWN: begin
            bus.ship_respawn = 1'b1;
            bus.ship_visible = 1'b1;
            state_nx         = INVULN;
         end
         INVULN: begin
            bus.ship_visible = blink_on;
            bus.thrust_en    = bus.thrust_btn;
            if (bus.frame_tick) begin
               if (frame_cnt == INV_LAST) state_nx = ALIVE;
               else frame_cnt_nx = frame_cnt + CW'(1);
            end
         end
         ALIVE: begin
            bus.ship_visible = 1'b1;
            bus.thrust_en    = bus.thrust_btn;
            bus.collide_en   = bus.collision;
            // collision takes priority; no frame timing runs here
            if (bus.collision) begin
               state_nx = EXPLODE;
               if (lives != '0) lives_nx = lives - LW'(1);
            end
         end
         EXPLODE: begin
            bus.explode_active = 1'b1;
            if (bus.frame_tick) begin
               if (frame_cnt == EXP_LAST) state_nx = (lives == '0) ? GAME_OVER : WAIT_RESP;
               else frame_cnt_nx = frame_cnt + CW'(1);
            end
         end
         WAIT_RESP: begin
            // counter parks at the hold-off length until the centre is clear
            if (frame_cnt == RESP_SAT) begin
               if (bus.spawn_clear) state_nx = SPAWN;
            end else if (bus.frame_tick) begin
               frame_cnt_nx = frame_cnt + CW'(1);
            end
         end
         GAME_OVER: begin
            bus.game_over = 1'b1;
            if (start_rise) begin
               state_nx = SPAWN;
               lives_nx = LIVES_INI;
            end
         end
         default: state_nx = IDLE;
      endcase

      if (state_nx != state) frame_cnt_nx = '0;
   end

   assign bus.lives_left = lives;
   assign bus.state_dbg  = state;
endmodule

// File: tb/tb_ship_life_ctrl.sv
// Bench for ship_life_ctrl: directed vector table with hand sequences for the
// multi-cycle corners, then random stimulus against a frame-countdown model.
module tb_ship_life_ctrl;
   localparam int T_LIVES = 2;
   localparam int T_INV   = 8;
   localparam int T_EXP   = 4;
   localparam int T_RESP  = 3;
   localparam int T_BL    = 1;

   localparam int P_IDLE = 0, P_SPAWN = 1, P_INVULN = 2, P_ALIVE = 3;
   localparam int P_EXPL = 4, P_WAIT = 5, P_GO = 6;

   logic clk;
   logic resetN;
   int   tick_cnt;
   int   n_tests;
   int   n_fail;

   ship_life_ctrl_if #(.LIVES(T_LIVES)) bus ();

   ship_life_ctrl #(
      .LIVES(T_LIVES), .INVULN_FRAMES(T_INV), .EXPLODE_FRAMES(T_EXP),
      .RESPAWN_FRAMES(T_RESP), .BLINK_LOG2(T_BL)
   ) dut (
      .clk(clk),
      .resetN(resetN),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // one frame tick every 10 clocks, changed on the falling edge
   initial begin
      tick_cnt       = 0;
      bus.frame_tick = 1'b0;
      forever begin
         @(negedge clk);
         if (!resetN) begin
            tick_cnt       = 0;
            bus.frame_tick = 1'b0;
         end else begin
            tick_cnt       = (tick_cnt == 9) ? 0 : tick_cnt + 1;
            bus.frame_tick = (tick_cnt == 9);
         end
      end
   end

   typedef struct {
      string      name;
      int         ticks;
      int         clks;
      bit         start, coll, clear, thrust;
      logic [10:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(string name, int ticks, int clks,
                               bit start, bit coll, bit clear, bit thrust,
                               int st, int lives, bit resp, bit vis, bit thr,
                               bit cen, bit expl, bit go);
      vec_t v;
      v.name   = name;
      v.ticks  = ticks;
      v.clks   = clks;
      v.start  = start;
      v.coll   = coll;
      v.clear  = clear;
      v.thrust = thrust;
      v.exp    = {st[2:0], lives[1:0], resp, vis, thr, cen, expl, go};
      return v;
   endfunction

   function automatic logic [10:0] get_out();
      return {bus.state_dbg, bus.lives_left, bus.ship_respawn, bus.ship_visible,
              bus.thrust_en, bus.collide_en, bus.explode_active, bus.game_over};
   endfunction

   task automatic check_vec(string name, logic [10:0] got, logic [10:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got st=%0d lives=%0d resp/vis/thr/cen/expl/go=%b, want st=%0d lives=%0d resp/vis/thr/cen/expl/go=%b",
                  name, got[10:8], got[7:6], got[5:0], exp[10:8], exp[7:6], exp[5:0]);
      end
   endtask

   task automatic check1(string name, logic got, logic exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, want %b", name, got, exp);
      end
   endtask

   task automatic nclk();
      @(negedge clk);
      #1;
   endtask

   task automatic advance(int ticks, int clks);
      for (int t = 0; t < ticks; t++) begin
         int guard;
         bit seen;
         guard = 0;
         seen  = 1'b0;
         while (!seen && guard < 40) begin
            @(posedge clk);
            seen = bus.frame_tick;
            guard++;
         end
         if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL tick_timeout: got no frame_tick in 40 clk, want one");
         end
      end
      repeat (clks) @(posedge clk);
      nclk();
   endtask

   task automatic apply_range(int lo, int hi);
      for (int i = lo; i <= hi; i++) begin
         bus.start_game  = tbl[i].start;
         bus.collision   = tbl[i].coll;
         bus.spawn_clear = tbl[i].clear;
         bus.thrust_btn  = tbl[i].thrust;
         advance(tbl[i].ticks, tbl[i].clks);
         check_vec(tbl[i].name, get_out(), tbl[i].exp);
      end
   endtask

   // reference model: counts frames down to zero per timed phase
   int m_ph, m_left, m_lives;
   bit m_sd;

   task automatic model_reset();
      m_ph    = P_IDLE;
      m_left  = 0;
      m_lives = 0;
      m_sd    = 1'b0;
   endtask

   task automatic model_step(bit tick, bit st, bit co, bit cl);
      bit rise;
      rise = st && !m_sd;
      m_sd = st;
      case (m_ph)
         P_IDLE, P_GO: if (rise) begin m_ph = P_SPAWN; m_lives = T_LIVES; end
         P_SPAWN: begin m_ph = P_INVULN; m_left = T_INV; end
         P_INVULN: if (tick) begin
            m_left--;
            if (m_left == 0) m_ph = P_ALIVE;
         end
         P_ALIVE: if (co) begin
            m_ph   = P_EXPL;
            m_left = T_EXP;
            if (m_lives > 0) m_lives--;
         end
         P_EXPL: if (tick) begin
            m_left--;
            if (m_left == 0) begin
               m_ph   = (m_lives == 0) ? P_GO : P_WAIT;
               m_left = T_RESP;
            end
         end
         P_WAIT: begin
            if (m_left == 0 && cl) m_ph = P_SPAWN;
            else if (tick && m_left > 0) m_left--;
         end
         default: m_ph = P_IDLE;
      endcase
   endtask

   function automatic logic [10:0] model_out(bit thrust, bit co);
      int  elapsed;
      bit  vis, thr, cen;
      elapsed = T_INV - m_left;
      vis = (m_ph == P_SPAWN) || (m_ph == P_ALIVE) ||
            (m_ph == P_INVULN && ((elapsed >> T_BL) % 2) == 0);
      thr = thrust && (m_ph == P_INVULN || m_ph == P_ALIVE);
      cen = co && (m_ph == P_ALIVE);
      return {m_ph[2:0], m_lives[1:0], (m_ph == P_SPAWN), vis, thr, cen,
              (m_ph == P_EXPL), (m_ph == P_GO)};
   endfunction

   initial begin
      bit resp_seen;
      n_tests = 0;
      n_fail  = 0;
      resetN  = 1'b0;
      bus.start_game  = 1'b0;
      bus.collision   = 1'b0;
      bus.spawn_clear = 1'b1;
      bus.thrust_btn  = 1'b0;

      //                 name             tk clk st co cl th  st lv rs vi th ce ex go
      tbl.push_back(mk("start_rise",      0, 1, 1, 0, 1, 0,  1, 2, 1, 1, 0, 0, 0, 0)); // 0
      tbl.push_back(mk("spawn_one_clk",   0, 1, 1, 0, 1, 1,  2, 2, 0, 1, 1, 0, 0, 0)); // 1
      tbl.push_back(mk("blink_f1",        1, 0, 1, 1, 1, 1,  2, 2, 0, 1, 1, 0, 0, 0)); // 2
      tbl.push_back(mk("blink_f2",        1, 0, 1, 1, 1, 1,  2, 2, 0, 0, 1, 0, 0, 0)); // 3
      tbl.push_back(mk("blink_f3",        1, 0, 1, 1, 1, 1,  2, 2, 0, 0, 1, 0, 0, 0)); // 4
      tbl.push_back(mk("blink_f4",        1, 0, 1, 1, 1, 1,  2, 2, 0, 1, 1, 0, 0, 0)); // 5
      tbl.push_back(mk("blink_f5",        1, 0, 1, 1, 1, 1,  2, 2, 0, 1, 1, 0, 0, 0)); // 6
      tbl.push_back(mk("blink_f6",        1, 0, 1, 1, 1, 1,  2, 2, 0, 0, 1, 0, 0, 0)); // 7
      tbl.push_back(mk("blink_f7",        1, 0, 1, 1, 1, 1,  2, 2, 0, 0, 1, 0, 0, 0)); // 8
      tbl.push_back(mk("alive_on_8th",    1, 0, 1, 0, 1, 0,  3, 2, 0, 1, 0, 0, 0, 0)); // 9
      tbl.push_back(mk("alive_thrust",    0, 1, 1, 0, 1, 1,  3, 2, 0, 1, 1, 0, 0, 0)); // 10
      tbl.push_back(mk("explode_f3",      3, 0, 1, 0, 0, 1,  4, 1, 0, 0, 0, 0, 1, 0)); // 11
      tbl.push_back(mk("wait_resp",       1, 0, 1, 0, 0, 1,  5, 1, 0, 0, 0, 0, 0, 0)); // 12
      tbl.push_back(mk("blocked_10f",    10, 0, 1, 0, 0, 1,  5, 1, 0, 0, 0, 0, 0, 0)); // 13
      tbl.push_back(mk("spawn_clear",     0, 1, 1, 0, 1, 1,  1, 1, 1, 1, 0, 0, 0, 0)); // 14
      tbl.push_back(mk("respawn_once",    0, 1, 1, 0, 1, 1,  2, 1, 0, 1, 1, 0, 0, 0)); // 15
      tbl.push_back(mk("alive2",          8, 0, 1, 0, 1, 1,  3, 1, 0, 1, 1, 0, 0, 0)); // 16
      tbl.push_back(mk("explode2_f3",     3, 0, 1, 0, 1, 0,  4, 0, 0, 0, 0, 0, 1, 0)); // 17
      tbl.push_back(mk("game_over",       1, 0, 1, 0, 1, 0,  6, 0, 0, 0, 0, 0, 0, 1)); // 18
      tbl.push_back(mk("go_start_held",   5, 0, 1, 0, 1, 0,  6, 0, 0, 0, 0, 0, 0, 1)); // 19
      tbl.push_back(mk("go_release",      0, 2, 0, 0, 1, 0,  6, 0, 0, 0, 0, 0, 0, 1)); // 20
      tbl.push_back(mk("restart",         0, 1, 1, 0, 1, 0,  1, 2, 1, 1, 0, 0, 0, 0)); // 21
      tbl.push_back(mk("restart_invuln",  0, 1, 1, 0, 1, 0,  2, 2, 0, 1, 0, 0, 0, 0)); // 22
      tbl.push_back(mk("alive3",          8, 0, 1, 0, 1, 0,  3, 2, 0, 1, 0, 0, 0, 0)); // 23

      repeat (3) @(posedge clk);
      nclk();
      check_vec("reset_state", get_out(), 11'd0);
      resetN = 1'b1;

      apply_range(0, 10);

      // death on a clock that also carries a frame tick
      begin
         int guard;
         guard = 0;
         while (!bus.frame_tick && guard < 40) begin nclk(); guard++; end
         check1("tick_found", bus.frame_tick, 1'b1);
      end
      bus.collision = 1'b1;
      #1;
      check1("collide_en_alive", bus.collide_en, 1'b1);
      @(posedge clk);
      nclk();
      bus.collision = 1'b0;
      check_vec("death1_explode", get_out(), {3'd4, 2'd1, 6'b000010});

      apply_range(11, 16);

      bus.collision = 1'b1;
      @(posedge clk);
      nclk();
      bus.collision = 1'b0;
      check_vec("death2_explode", get_out(), {3'd4, 2'd0, 6'b000010});

      apply_range(17, 23);

      bus.collision = 1'b1;
      @(posedge clk);
      nclk();
      bus.collision = 1'b0;
      check_vec("death3_explode", get_out(), {3'd4, 2'd1, 6'b000010});
      advance(1, 0);
      resetN         = 1'b0;
      bus.start_game = 1'b0;
      #1;
      check_vec("async_reset", get_out(), 11'd0);
      repeat (3) @(posedge clk);
      nclk();
      resetN    = 1'b1;
      resp_seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         nclk();
         if (bus.ship_respawn || bus.state_dbg != 3'd0) resp_seen = 1'b1;
      end
      check1("no_respawn_after_reset", resp_seen, 1'b0);
      bus.start_game = 1'b1;
      @(posedge clk);
      nclk();
      check_vec("start_after_reset", get_out(), {3'd1, 2'd2, 6'b110000});

      // randomized run against the model
      resetN         = 1'b0;
      bus.start_game = 1'b0;
      bus.collision  = 1'b0;
      bus.thrust_btn = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      nclk();
      resetN = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         nclk();
         if ($urandom_range(0, 19) == 0) bus.start_game = ~bus.start_game;
         bus.collision   = ($urandom_range(0, 29) == 0);
         bus.spawn_clear = ($urandom_range(0, 3) != 0);
         bus.thrust_btn  = $urandom_range(0, 1);
         #1;
         check_vec("random", get_out(), model_out(bus.thrust_btn, bus.collision));
         @(posedge clk);
         model_step(bus.frame_tick, bus.start_game, bus.collision, bus.spawn_clear);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
